// File: rtl/axo_csr_file_pkg.sv
// rtl/axo_csr_file_pkg.sv - CSR address map, misa value and FSM state type for the Axolotl CSR file
package axo_csr_file_pkg;

   localparam logic [11:0] RV_CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] RV_CSR_MISA      = 12'h301;
   localparam logic [11:0] RV_CSR_MIE       = 12'h304;
   localparam logic [11:0] RV_CSR_MTVEC     = 12'h305;
   localparam logic [11:0] RV_CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] RV_CSR_MEPC      = 12'h341;
   localparam logic [11:0] RV_CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] RV_CSR_MTVAL     = 12'h343;
   localparam logic [11:0] RV_CSR_MIP       = 12'h344;
   localparam logic [11:0] RV_CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] RV_CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] RV_CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] RV_CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] RV_CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] RV_CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] RV_CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] RV_CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] RV_CSR_MHARTID   = 12'hF14;

   localparam logic [31:0] RV_MISA_VALUE = 32'h4000_0100;

   typedef enum logic {
      ST_IDLE,
      ST_RESP
   } csr_state_e;

   // Top two address bits 2'b11 mark the read-only CSR space.
   function automatic logic csr_read_only(input logic [11:0] addr);
      return addr[11:10] == 2'b11;
   endfunction

endpackage

// File: rtl/axo_csr_helper.sv
// rtl/axo_csr_helper.sv - new CSR value from old value, SYSTEM funct3 and bitmask
module axo_csr_helper #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] old_value,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] bitmask,
   input  logic            write,
   output logic [XLEN-1:0] new_value,
   output logic            op_valid
);

   always_comb begin
      new_value = old_value;
      op_valid  = 1'b1;
      case (funct3)
         3'b001, 3'b101: if (write) new_value = bitmask;
         3'b010, 3'b110: if (write) new_value = old_value | bitmask;
         3'b011, 3'b111: if (write) new_value = old_value & ~bitmask;
         default:        op_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/axo_csr_file.sv
// rtl/axo_csr_file.sv - machine-mode CSR storage, counters and trap state with a request/response port
module axo_csr_file
   import axo_csr_file_pkg::*;
#(
   parameter int              XLEN    = 32,
   parameter logic [XLEN-1:0] HART_ID = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [11:0]     req_addr,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_bitmask,
   input  logic            req_write,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_illegal,
   input  logic            retire,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_tval,
   input  logic            mret,
   output logic [XLEN-1:0] mtvec_o,
   output logic [XLEN-1:0] mepc_o,
   output logic            irq_en_o
);

   localparam logic [2*XLEN-1:0] CNT_ONE = {{(2*XLEN-1){1'b0}}, 1'b1};

   csr_state_e        state;
   logic [2*XLEN-1:0] mcycle;
   logic [2*XLEN-1:0] minstret;
   logic [2*XLEN-1:0] mcycle_inc;
   logic [2*XLEN-1:0] minstret_inc;
   logic [XLEN-1:0]   mie_csr;
   logic [XLEN-1:0]   mtvec;
   logic [XLEN-1:0]   mscratch;
   logic [XLEN-1:0]   mepc;
   logic [XLEN-1:0]   mcause;
   logic [XLEN-1:0]   mtval;
   logic              mstatus_mie;
   logic              mstatus_mpie;

   logic [XLEN-1:0]   rd_value;
   logic [XLEN-1:0]   new_value;
   logic              mapped;
   logic              op_valid;
   logic              illegal;
   logic              accept;
   logic              wr_en;
   logic              wr_mstatus, wr_mie, wr_mtvec, wr_mscratch;
   logic              wr_mepc, wr_mcause, wr_mtval;
   logic              wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

   always_comb begin
      rd_value = '0;
      mapped   = 1'b1;
      case (req_addr)
         RV_CSR_MSTATUS: begin
            rd_value[12:11] = 2'b11;
            rd_value[7]     = mstatus_mpie;
            rd_value[3]     = mstatus_mie;
         end
         RV_CSR_MISA:                       rd_value = RV_MISA_VALUE;
         RV_CSR_MIE:                        rd_value = mie_csr;
         RV_CSR_MTVEC:                      rd_value = mtvec;
         RV_CSR_MSCRATCH:                   rd_value = mscratch;
         RV_CSR_MEPC:                       rd_value = mepc;
         RV_CSR_MCAUSE:                     rd_value = mcause;
         RV_CSR_MTVAL:                      rd_value = mtval;
         RV_CSR_MIP:                        rd_value = '0;
         RV_CSR_MCYCLE,   RV_CSR_CYCLE:     rd_value = mcycle[XLEN-1:0];
         RV_CSR_MCYCLEH,  RV_CSR_CYCLEH:    rd_value = mcycle[2*XLEN-1:XLEN];
         RV_CSR_MINSTRET, RV_CSR_INSTRET:   rd_value = minstret[XLEN-1:0];
         RV_CSR_MINSTRETH, RV_CSR_INSTRETH: rd_value = minstret[2*XLEN-1:XLEN];
         RV_CSR_MHARTID:                    rd_value = HART_ID;
         default:                           mapped   = 1'b0;
      endcase
   end

   axo_csr_helper #(
      .XLEN(XLEN)
   ) u_helper (
      .old_value(rd_value),
      .funct3   (req_funct3),
      .bitmask  (req_bitmask),
      .write    (req_write),
      .new_value(new_value),
      .op_valid (op_valid)
   );

   assign illegal = !mapped || !op_valid || (req_write && csr_read_only(req_addr));
   assign accept  = req_valid && req_ready;
   assign wr_en   = accept && !illegal && req_write;

   // misa and mip are absent here: writes to them are accepted and ignored.
   assign wr_mstatus   = wr_en && (req_addr == RV_CSR_MSTATUS);
   assign wr_mie       = wr_en && (req_addr == RV_CSR_MIE);
   assign wr_mtvec     = wr_en && (req_addr == RV_CSR_MTVEC);
   assign wr_mscratch  = wr_en && (req_addr == RV_CSR_MSCRATCH);
   assign wr_mepc      = wr_en && (req_addr == RV_CSR_MEPC);
   assign wr_mcause    = wr_en && (req_addr == RV_CSR_MCAUSE);
   assign wr_mtval     = wr_en && (req_addr == RV_CSR_MTVAL);
   assign wr_mcycle    = wr_en && (req_addr == RV_CSR_MCYCLE);
   assign wr_mcycleh   = wr_en && (req_addr == RV_CSR_MCYCLEH);
   assign wr_minstret  = wr_en && (req_addr == RV_CSR_MINSTRET);
   assign wr_minstreth = wr_en && (req_addr == RV_CSR_MINSTRETH);

   assign mcycle_inc   = mcycle + CNT_ONE;
   assign minstret_inc = minstret + {{(2*XLEN-1){1'b0}}, retire};

   assign mtvec_o  = mtvec;
   assign mepc_o   = mepc;
   assign irq_en_o = mstatus_mie;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         req_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         resp_illegal <= 1'b0;
         mcycle       <= '0;
         minstret     <= '0;
         mie_csr      <= '0;
         mtvec        <= '0;
         mscratch     <= '0;
         mepc         <= '0;
         mcause       <= '0;
         mtval        <= '0;
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
      end else begin
         // A write to one half replaces it outright; the other half keeps the incremented value.
         mcycle <= mcycle_inc;
         if (wr_mcycle)    mcycle[XLEN-1:0]        <= new_value;
         if (wr_mcycleh)   mcycle[2*XLEN-1:XLEN]   <= new_value;
         minstret <= minstret_inc;
         if (wr_minstret)  minstret[XLEN-1:0]      <= new_value;
         if (wr_minstreth) minstret[2*XLEN-1:XLEN] <= new_value;

         if (wr_mie)      mie_csr  <= new_value;
         if (wr_mtvec)    mtvec    <= {new_value[XLEN-1:2], 2'b00};
         if (wr_mscratch) mscratch <= new_value;

         // Trap entry owns the trap CSRs this edge; a racing CSR write to them is dropped.
         if (trap_valid) begin
            mepc         <= {trap_pc[XLEN-1:2], 2'b00};
            mcause       <= trap_cause;
            mtval        <= trap_tval;
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else begin
            if (mret) begin
               mstatus_mie  <= mstatus_mpie;
               mstatus_mpie <= 1'b1;
            end else if (wr_mstatus) begin
               mstatus_mie  <= new_value[3];
               mstatus_mpie <= new_value[7];
            end
            if (wr_mepc)   mepc   <= {new_value[XLEN-1:2], 2'b00};
            if (wr_mcause) mcause <= new_value;
            if (wr_mtval)  mtval  <= new_value;
         end

         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  state        <= ST_RESP;
                  req_ready    <= 1'b0;
                  resp_valid   <= 1'b1;
                  resp_rdata   <= illegal ? '0 : rd_value;
                  resp_illegal <= illegal;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state      <= ST_IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
               end
            end
            default: begin
               state      <= ST_IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axo_csr_file.sv
// tb/tb_axo_csr_file.sv - self-checking bench for axo_csr_file against a behavioural CSR model
module tb_axo_csr_file;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [11:0] req_addr;
   logic [2:0]  req_funct3;
   logic [31:0] req_bitmask;
   logic        req_write;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_illegal;
   logic        retire;
   logic        trap_valid;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;
   logic [31:0] trap_tval;
   logic        mret;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;
   logic        irq_en_o;

   always #5 clk = ~clk;

   axo_csr_file #(
      .XLEN   (32),
      .HART_ID(32'd3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_funct3  (req_funct3),
      .req_bitmask (req_bitmask),
      .req_write   (req_write),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata),
      .resp_illegal(resp_illegal),
      .retire      (retire),
      .trap_valid  (trap_valid),
      .trap_pc     (trap_pc),
      .trap_cause  (trap_cause),
      .trap_tval   (trap_tval),
      .mret        (mret),
      .mtvec_o     (mtvec_o),
      .mepc_o      (mepc_o),
      .irq_en_o    (irq_en_o)
   );

   int errors = 0;
   int checks = 0;

   // Model state: raw values as the architecture sees them, masking applied on read.
   logic [63:0] m_cycle, m_instret;
   logic [31:0] m_mie_csr, m_mtvec, m_scratch, m_mepc, m_mcause, m_mtval;
   logic        m_mie, m_mpie;
   bit          m_busy, m_acc;
   logic [31:0] m_rdata;
   logic        m_illegal;

   logic [11:0] addr_pool [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                                   12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF14,
                                   12'h7C0, 12'h3A0};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a, output bit mapped);
      mapped = 1'b1;
      case (a)
         12'h300:          return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
         12'h301:          return 32'h4000_0100;
         12'h304:          return m_mie_csr;
         12'h305:          return m_mtvec & ~32'h3;
         12'h340:          return m_scratch;
         12'h341:          return m_mepc & ~32'h3;
         12'h342:          return m_mcause;
         12'h343:          return m_mtval;
         12'h344:          return 32'h0;
         12'hB00, 12'hC00: return m_cycle[31:0];
         12'hB80, 12'hC80: return m_cycle[63:32];
         12'hB02, 12'hC02: return m_instret[31:0];
         12'hB82, 12'hC82: return m_instret[63:32];
         12'hF14:          return 32'd3;
         default: begin
            mapped = 1'b0;
            return 32'h0;
         end
      endcase
   endfunction

   task automatic model_reset();
      m_cycle = '0; m_instret = '0;
      m_mie_csr = '0; m_mtvec = '0; m_scratch = '0;
      m_mepc = '0; m_mcause = '0; m_mtval = '0;
      m_mie = 1'b0; m_mpie = 1'b0;
      m_busy = 1'b0; m_acc = 1'b0;
      m_rdata = '0; m_illegal = 1'b0;
   endtask

   // Applies one rising edge using the inputs that were present at that edge.
   task automatic model_edge();
      logic [31:0] old_v, nv;
      logic [63:0] cyc, ins;
      bit          mapped, legal, wr;
      m_acc = 1'b0;
      wr    = 1'b0;
      nv    = '0;
      if (rst) begin
         model_reset();
         return;
      end
      if (req_valid && !m_busy) begin
         m_acc = 1'b1;
         old_v = m_read(req_addr, mapped);
         legal = mapped && req_funct3 != 3'd0 && req_funct3 != 3'd4 &&
                 !(req_write && req_addr >= 12'hC00);
         case (req_funct3 % 3'd4)
            3'd1:    nv = req_bitmask;
            3'd2:    nv = old_v | req_bitmask;
            default: nv = old_v & ~req_bitmask;
         endcase
         wr        = legal && req_write;
         m_busy    = 1'b1;
         m_rdata   = legal ? old_v : 32'h0;
         m_illegal = !legal;
      end else if (m_busy && resp_ready) begin
         m_busy = 1'b0;
      end
      cyc = m_cycle + 64'd1;
      ins = m_instret + (retire ? 64'd1 : 64'd0);
      if (wr) begin
         case (req_addr)
            12'hB00: cyc[31:0]  = nv;
            12'hB80: cyc[63:32] = nv;
            12'hB02: ins[31:0]  = nv;
            12'hB82: ins[63:32] = nv;
            12'h304: m_mie_csr  = nv;
            12'h305: m_mtvec    = nv;
            12'h340: m_scratch  = nv;
            default: ;
         endcase
      end
      m_cycle   = cyc;
      m_instret = ins;
      if (trap_valid) begin
         m_mepc   = trap_pc;
         m_mcause = trap_cause;
         m_mtval  = trap_tval;
         m_mpie   = m_mie;
         m_mie    = 1'b0;
      end else begin
         if (mret) begin
            m_mie  = m_mpie;
            m_mpie = 1'b1;
         end
         if (wr) begin
            case (req_addr)
               12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
               12'h341: m_mepc   = nv;
               12'h342: m_mcause = nv;
               12'h343: m_mtval  = nv;
               default: ;
            endcase
         end
      end
   endtask

   task automatic compare();
      check("req_ready", req_ready, !m_busy);
      check("resp_valid", resp_valid, m_busy);
      if (m_busy) begin
         check("resp_rdata", resp_rdata, m_rdata);
         check("resp_illegal", resp_illegal, m_illegal);
      end
      check("mtvec_o", mtvec_o, m_mtvec & ~32'h3);
      check("mepc_o", mepc_o, m_mepc & ~32'h3);
      check("irq_en_o", irq_en_o, m_mie);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic do_req(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] mask,
                         input logic w, output logic [31:0] rd, output logic ill);
      int n = 0;
      req_valid   = 1'b1;
      req_addr    = a;
      req_funct3  = f3;
      req_bitmask = mask;
      req_write   = w;
      resp_ready  = 1'b1;
      do begin
         step();
         n++;
      end while (!m_acc && n < 20);
      req_valid = 1'b0;
      check("req_accepted", resp_valid && n < 20, 1'b1);
      rd  = resp_rdata;
      ill = resp_illegal;
   endtask

   initial begin
      logic [31:0] rd, hold;
      logic        ill;
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_bitmask = '0;
      req_write = 1'b0; resp_ready = 1'b1; retire = 1'b0; trap_valid = 1'b0;
      trap_pc = '0; trap_cause = '0; trap_tval = '0; mret = 1'b0;
      model_reset();
      repeat (2) step();
      rst = 1'b0;
      check("reset_req_ready", req_ready, 1'b1);
      check("reset_resp_valid", resp_valid, 1'b0);
      check("reset_resp_rdata", resp_rdata, 32'h0);
      check("reset_resp_illegal", resp_illegal, 1'b0);

      do_req(12'h301, 3'b010, 32'h0, 1'b0, rd, ill);
      check("misa_rdata", rd, 32'h4000_0100);
      check("misa_illegal", ill, 1'b0);

      do_req(12'h340, 3'b001, 32'hDEAD_BEEF, 1'b1, rd, ill);
      check("mscratch_rw_old", rd, 32'h0);
      do_req(12'h340, 3'b010, 32'h0, 1'b0, rd, ill);
      check("mscratch_read", rd, 32'hDEAD_BEEF);

      do_req(12'h305, 3'b101, 32'h107, 1'b1, rd, ill);
      do_req(12'h305, 3'b010, 32'h0, 1'b0, rd, ill);
      check("mtvec_read", rd, 32'h104);
      check("mtvec_o_literal", mtvec_o, 32'h104);

      do_req(12'hF14, 3'b001, 32'h55, 1'b1, rd, ill);
      check("mhartid_wr_illegal", ill, 1'b1);
      check("mhartid_wr_rdata", rd, 32'h0);
      do_req(12'hF14, 3'b010, 32'h0, 1'b0, rd, ill);
      check("mhartid_read", rd, 32'd3);
      do_req(12'h7C0, 3'b010, 32'h0, 1'b0, rd, ill);
      check("unmapped_illegal", ill, 1'b1);
      do_req(12'h340, 3'b100, 32'h0, 1'b0, rd, ill);
      check("funct3_illegal", ill, 1'b1);

      do_req(12'hB80, 3'b001, 32'hFFFF_FFFF, 1'b1, rd, ill);
      check("mcycleh_old", rd, 32'h0);
      do_req(12'hB00, 3'b001, 32'hFFFF_FFFF, 1'b1, rd, ill);
      do_req(12'hB00, 3'b010, 32'h0, 1'b0, rd, ill);
      check("mcycle_wrapped_lo", rd, 32'h0);
      do_req(12'hB80, 3'b010, 32'h0, 1'b0, rd, ill);
      check("mcycle_wrapped_hi", rd, 32'h0);
      do_req(12'hC00, 3'b010, 32'h0, 1'b0, rd, ill);
      check("cycle_mirror", rd, 32'd4);

      do_req(12'h300, 3'b010, 32'h8, 1'b1, rd, ill);
      check("mstatus_initial", rd, 32'h1800);
      step();
      req_valid = 1'b1; req_addr = 12'h341; req_funct3 = 3'b001;
      req_bitmask = 32'h40; req_write = 1'b1;
      trap_valid = 1'b1; trap_pc = 32'h80; trap_cause = 32'hB; trap_tval = 32'h1234;
      step();
      req_valid = 1'b0; trap_valid = 1'b0;
      check("trap_req_resp", resp_valid, 1'b1);
      check("trap_mepc_old", resp_rdata, 32'h0);
      check("trap_mepc", mepc_o, 32'h80);
      check("trap_mie_clear", irq_en_o, 1'b0);
      do_req(12'h300, 3'b010, 32'h0, 1'b0, rd, ill);
      check("mstatus_after_trap", rd, 32'h1880);
      mret = 1'b1;
      step();
      mret = 1'b0;
      check("mret_mie", irq_en_o, 1'b1);
      do_req(12'h300, 3'b010, 32'h0, 1'b0, rd, ill);
      check("mstatus_after_mret", rd, 32'h1888);
      do_req(12'h342, 3'b010, 32'h0, 1'b0, rd, ill);
      check("mcause_trap", rd, 32'hB);

      step();
      req_valid = 1'b1; req_addr = 12'h340; req_funct3 = 3'b001;
      req_bitmask = 32'h1234_5678; req_write = 1'b1; resp_ready = 1'b0;
      step();
      req_valid = 1'b0;
      hold = resp_rdata;
      check("hold_first_rdata", hold, 32'hDEAD_BEEF);
      repeat (3) step();
      check("hold_rdata_stable", resp_rdata, hold);
      check("hold_req_ready", req_ready, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_resp_valid", resp_valid, 1'b0);
      check("rst_mid_req_ready", req_ready, 1'b1);
      do_req(12'h340, 3'b010, 32'h0, 1'b0, rd, ill);
      check("mscratch_after_rst", rd, 32'h0);

      for (int c = 0; c < 4000; c++) begin
         rst         = ($urandom_range(0, 299) == 0);
         req_valid   = 1'($urandom_range(0, 1));
         req_addr    = addr_pool[$urandom_range(0, 19)];
         req_funct3  = 3'($urandom_range(0, 7));
         req_bitmask = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
         req_write   = ($urandom_range(0, 3) != 0);
         resp_ready  = ($urandom_range(0, 3) != 0);
         retire      = 1'($urandom_range(0, 1));
         trap_valid  = ($urandom_range(0, 15) == 0);
         trap_pc     = $urandom;
         trap_cause  = $urandom;
         trap_tval   = $urandom;
         mret        = ($urandom_range(0, 15) == 0) && !(req_valid && req_addr == 12'h300);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
